// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, LFSR constants and address check for the data-memory responder
package dmem_pkg;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;
  typedef struct packed {
    logic        vld;
    logic        we;
    logic        err;
    logic [31:0] rdata;
  } dmem_tag_t;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  function automatic logic addr_err(input logic [31:0] addr, input int depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth_words));
  endfunction
endpackage

// File: rtl/dmem_rsp_fifo.sv
// dmem_rsp_fifo: DEPTH-entry response FIFO, head driven to zero when empty
//   push/din   : write an entry (caller guarantees space)
//   pop        : remove head when valid
//   dout/valid : head entry and non-empty flag
//   count      : current occupancy
module dmem_rsp_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  dmem_rsp_t     din,
  input  logic          pop,
  output dmem_rsp_t     dout,
  output logic          valid,
  output logic [CW-1:0] count
);
  dmem_rsp_t     mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;
  always_comb begin
    valid  = cnt_q != '0;
    do_pop = pop & valid;
    wr_d   = push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d   = do_pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d  = cnt_q + CW'(push) - CW'(do_pop);
    dout   = valid ? mem_q[rd_q] : '0;
    count  = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with fixed-latency in-order responses and a response buffer
//   req_* : valid/ready request (we, byte addr, wdata, wstrb)
//   rsp_* : valid/ready response (rdata, err)
//   DMEM_STALL_INJECT_EN: LFSR-driven pseudo-random req_ready stalls
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int RSP_DEPTH   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int FW = $clog2(RSP_DEPTH + 1);
  localparam int CW = FW + 1;
  logic [31:0]   mem [DEPTH_WORDS];
  dmem_tag_t     pipe_q [LATENCY];
  dmem_tag_t     pipe_d [LATENCY];
  logic [CW-1:0] inflight_q, inflight_d;
  logic [FW-1:0] buf_count;
  logic [AW-1:0] idx;
  logic          accept, req_err, stall, push;
  dmem_rsp_t     push_rsp, head;
`ifdef DMEM_STALL_INJECT_EN
  logic [7:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    stall  = lfsr_q[0];
  end
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else lfsr_q <= lfsr_d;
  end
`else
  always_comb stall = 1'b0;
`endif
  always_comb begin
    req_err    = addr_err(req_addr, DEPTH_WORDS);
    idx        = req_addr[AW+1:2];
    // credits cover both in-flight pipe entries and buffered responses, so the buffer can never overflow
    req_ready  = ~rst & ~stall & ((inflight_q + CW'(buf_count)) < CW'(RSP_DEPTH));
    accept     = req_valid & req_ready;
    pipe_d[0]  = '{vld: accept, we: req_we, err: req_err, rdata: mem[idx]};
    for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    push       = pipe_q[LATENCY-1].vld;
    push_rsp   = '{rdata: (pipe_q[LATENCY-1].we | pipe_q[LATENCY-1].err) ? '0 : pipe_q[LATENCY-1].rdata,
                   err: pipe_q[LATENCY-1].err};
    inflight_d = inflight_q + CW'(accept) - CW'(push);
    rsp_rdata  = head.rdata;
    rsp_err    = head.err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      inflight_q <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
      inflight_q <= inflight_d;
    end
  end
  // storage is never reset so committed stores survive rst
  always_ff @(posedge clk) begin
    if (accept & req_we & ~req_err)
      for (int b = 0; b < 4; b++)
        if (req_wstrb[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
  end
  dmem_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (push_rsp),
    .pop  (rsp_ready),
    .dout (head),
    .valid(rsp_valid),
    .count(buf_count)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table, back-pressure, reset and random checks for dmem_responder
module tb_dmem_responder;
  logic        clk, rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_wstrb;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  typedef struct {bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic [31:0] er; bit ee;} vec_t;
  exp_t        q[$];
  logic [31:0] mdl [256];
  vec_t        vt [20];
  logic [31:0] bp [6];
  int          total = 0, bad = 0, n_acc = 0, n_pop = 0;

  dmem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(output bit acc);
    exp_t e;
    bit   er;
    int   ix;
    acc = req_valid && req_ready;
    if (acc) begin
      er = (req_addr[1:0] != 2'b00) || (req_addr >= 32'h400);
      ix = int'(req_addr[9:2]);
      e.rdata = '0;
      if (req_we) begin
        if (!er) for (int b = 0; b < 4; b++) if (req_wstrb[b]) mdl[ix][8*b +: 8] = req_wdata[8*b +: 8];
      end else if (!er) e.rdata = mdl[ix];
      e.err = er;
      q.push_back(e);
      n_acc++;
    end
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_rsp: got rdata %h err %b want no response", rsp_rdata, rsp_err);
      end else begin
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
      n_pop++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_one(input string nm, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] er, input bit ee);
    bit acc;
    int n;
    req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    req_valid = 1; rsp_ready = 0; acc = 0; n = 0;
    while (!acc && n < 40) begin step(acc); n++; end
    chk({nm, "_accepted"}, 32'(acc), 32'd1);
    req_valid = 0; n = 0;
    while (!rsp_valid && n < 20) begin step(acc); n++; end
    chk({nm, "_latency"}, n, 2);
    chk({nm, "_rdata"}, rsp_rdata, er);
    chk({nm, "_err"}, 32'(rsp_err), 32'(ee));
    rsp_ready = 1;
    step(acc);
    rsp_ready = 0;
    chk({nm, "_empty_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_empty_rdata"}, rsp_rdata, 32'd0);
  endtask

  initial begin
    bit acc;
    int k, w, spur, issued, cyc, base;
    vt[0]  = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0};
    vt[1]  = '{0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0};
    vt[2]  = '{1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 0};
    vt[3]  = '{0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0};
    vt[4]  = '{0, 32'h13, 32'h0, 4'h0, 32'h0, 1};
    vt[5]  = '{0, 32'h400, 32'h0, 4'h0, 32'h0, 1};
    vt[6]  = '{1, 32'h0, 32'h11111111, 4'hF, 32'h0, 0};
    vt[7]  = '{1, 32'h400, 32'h12345678, 4'hF, 32'h0, 1};
    vt[8]  = '{0, 32'h0, 32'h0, 4'h0, 32'h11111111, 0};
    vt[9]  = '{1, 32'h11, 32'hFFFFFFFF, 4'hF, 32'h0, 1};
    vt[10] = '{0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0};
    vt[11] = '{1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 0};
    vt[12] = '{0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0};
    vt[13] = '{1, 32'h3FC, 32'h0000BEEF, 4'hF, 32'h0, 0};
    vt[14] = '{1, 32'h3FC, 32'hCAFE0000, 4'hC, 32'h0, 0};
    vt[15] = '{0, 32'h3FC, 32'h0, 4'h0, 32'hCAFEBEEF, 0};
    vt[16] = '{1, 32'h0, 32'h00ABCD00, 4'h6, 32'h0, 0};
    vt[17] = '{0, 32'h0, 32'h0, 4'h0, 32'h11ABCD11, 0};
    vt[18] = '{0, 32'hFFFFFFFC, 32'h0, 4'h0, 32'h0, 1};
    vt[19] = '{0, 32'h3FE, 32'h0, 4'h0, 32'h0, 1};
    bp = '{32'h10, 32'h0, 32'h3FC, 32'h10, 32'h13, 32'h0};
    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 0;
    #1;
`ifndef DMEM_STALL_INJECT_EN
    chk("post_rst_ready", 32'(req_ready), 32'd1);
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++)
      do_one($sformatf("v%0d", i), vt[i].we, vt[i].addr, vt[i].wdata, vt[i].strb, vt[i].er, vt[i].ee);

    // back-pressure: six loads offered with rsp_ready low
    rsp_ready = 0; req_we = 0; req_wdata = 0; req_wstrb = 0; k = 0; base = n_pop;
    for (int c = 0; c < 20; c++) begin
      req_valid = k < 6;
      req_addr = bp[k < 6 ? k : 5];
      step(acc);
      if (acc) k++;
    end
    chk("bp_accepted", k, 3);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_head_held", rsp_rdata, 32'hDEADBEAA);
    rsp_ready = 1; w = 0;
    while ((k < 6 || q.size() != 0) && w < 100) begin
      req_valid = k < 6;
      req_addr = bp[k < 6 ? k : 5];
      step(acc);
      if (acc) k++;
      w++;
    end
    req_valid = 0; rsp_ready = 0;
    chk("bp_all_popped", n_pop - base, 6);

    // reset with two loads in flight
    do_one("rst_store", 1, 32'h20, 32'h55AA55AA, 4'hF, 32'h0, 0);
    req_valid = 1; req_we = 0; req_addr = 32'h10; k = 0; w = 0;
    while (k < 2 && w < 40) begin step(acc); if (acc) k++; w++; end
    req_valid = 0;
    chk("rst_two_accepted", k, 2);
    rst = 1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    step(acc);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    q.delete();
    step(acc);
    rst = 0; spur = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) spur++;
      step(acc);
    end
    chk("rst_dropped", spur, 0);
    do_one("rst_persist", 0, 32'h20, 32'h0, 4'h0, 32'h55AA55AA, 0);
    do_one("rst_persist2", 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0);

    // random traffic against the model
    issued = 0; cyc = 0; base = n_pop; req_valid = 0;
    while ((issued < 400 || q.size() != 0) && cyc < 20000) begin
      if (!req_valid && issued < 400 && $urandom_range(3) != 0) begin
        k = issued < 8 ? issued : int'($urandom_range(7));
        w = issued < 8 ? 2 : int'($urandom_range(9));
        req_addr = w == 0 ? 32'h400 + 32'(k * 4) : w == 1 ? 32'(k * 4) + 32'($urandom_range(1, 3)) : 32'(k * 4);
        req_we = issued < 8 ? 1'b1 : 1'($urandom_range(1));
        req_wstrb = issued < 8 ? 4'hF : 4'($urandom_range(15));
        req_wdata = $urandom;
        req_valid = 1;
      end
      rsp_ready = $urandom_range(3) != 0;
      step(acc);
      if (acc) begin issued++; req_valid = 0; end
      cyc++;
    end
    chk("rand_issued", issued, 400);
    chk("rand_outstanding", q.size(), 0);
    chk("rand_popped", n_pop - base, 400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
